// File: rtl/fp_add_pipe.sv
// Five-stage pipelined floating-point adder/subtractor: flush-to-zero inputs,
// round-to-nearest-even, one global stall driven by the result handshake.
module fp_add_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    input  logic                  sub,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  arg_vld,
    output logic                  arg_rdy,
    output logic [EXP_W+MANT_W:0] result,
    output logic [1:0]            state,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  res_vld,
    input  logic                  res_rdy
);
    localparam int W   = 1 + EXP_W + MANT_W;
    localparam int XW  = MANT_W + 4;
    localparam int EXW = EXP_W + 2;
    localparam int LZW = $clog2(XW + 1);
    localparam int SHW = $clog2(XW);
    localparam int MRW = MANT_W + 2;
    localparam logic [EXP_W-1:0] EMAX  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] CAP_E = EXP_W'(MANT_W + 3);
    localparam logic [SHW-1:0]   CAP_S = SHW'(MANT_W + 3);

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;
    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_NAN = 2'b01,
        ST_INF = 2'b10,
        ST_NUL = 2'b11
    } status_t;

    logic stall;
    logic advance;

    assign stall   = res_vld && !res_rdy;
    assign advance = !stall;
    assign arg_rdy = advance;

    // Operand capture on the accept edge.
    logic             s0_vld;
    logic [W-1:0]     s0_a;
    logic [W-1:0]     s0_b;
    logic             s0_sub;
    logic [TAG_W-1:0] s0_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_vld <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
            s0_sub <= 1'b0;
            s0_tag <= '0;
        end else if (advance) begin
            s0_vld <= arg_vld;
            s0_a   <= a;
            s0_b   <= b;
            s0_sub <= sub;
            s0_tag <= tag_in;
        end
    end

    // S1: unpack, flush subnormals, resolve NaN/inf/double-zero up front.
    logic             u_sa;
    logic             u_sb;
    logic [EXP_W-1:0] u_ea;
    logic [EXP_W-1:0] u_eb;
    logic [MANT_W:0]  u_ma;
    logic [MANT_W:0]  u_mb;
    logic             u_zero_a;
    logic             u_zero_b;
    logic             u_inf_a;
    logic             u_inf_b;
    logic             u_nan_a;
    logic             u_nan_b;
    special_t         u_sp;
    logic             u_sp_sign;

    always_comb begin
        u_sa      = s0_a[W-1];
        u_sb      = s0_b[W-1] ^ s0_sub;
        u_ea      = s0_a[W-2:MANT_W];
        u_eb      = s0_b[W-2:MANT_W];
        u_zero_a  = (u_ea == '0);
        u_zero_b  = (u_eb == '0);
        u_inf_a   = (u_ea == EMAX) && (s0_a[MANT_W-1:0] == '0);
        u_inf_b   = (u_eb == EMAX) && (s0_b[MANT_W-1:0] == '0);
        u_nan_a   = (u_ea == EMAX) && (s0_a[MANT_W-1:0] != '0);
        u_nan_b   = (u_eb == EMAX) && (s0_b[MANT_W-1:0] != '0);
        u_ma      = u_zero_a ? '0 : {1'b1, s0_a[MANT_W-1:0]};
        u_mb      = u_zero_b ? '0 : {1'b1, s0_b[MANT_W-1:0]};
        u_sp      = SP_NONE;
        u_sp_sign = 1'b0;
        if (u_nan_a || u_nan_b || (u_inf_a && u_inf_b && (u_sa != u_sb))) begin
            u_sp = SP_NAN;
        end else if (u_inf_a || u_inf_b) begin
            u_sp      = SP_INF;
            u_sp_sign = u_inf_a ? u_sa : u_sb;
        end else if (u_zero_a && u_zero_b) begin
            u_sp      = SP_ZERO;
            u_sp_sign = u_sa && u_sb;
        end
    end

    logic             s1_vld;
    logic             s1_sa;
    logic             s1_sb;
    logic [EXP_W-1:0] s1_ea;
    logic [EXP_W-1:0] s1_eb;
    logic [MANT_W:0]  s1_ma;
    logic [MANT_W:0]  s1_mb;
    special_t         s1_sp;
    logic             s1_sp_sign;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld     <= 1'b0;
            s1_sa      <= 1'b0;
            s1_sb      <= 1'b0;
            s1_ea      <= '0;
            s1_eb      <= '0;
            s1_ma      <= '0;
            s1_mb      <= '0;
            s1_sp      <= SP_NONE;
            s1_sp_sign <= 1'b0;
            s1_tag     <= '0;
        end else if (advance) begin
            s1_vld     <= s0_vld;
            s1_sa      <= u_sa;
            s1_sb      <= u_sb;
            s1_ea      <= u_ea;
            s1_eb      <= u_eb;
            s1_ma      <= u_ma;
            s1_mb      <= u_mb;
            s1_sp      <= u_sp;
            s1_sp_sign <= u_sp_sign;
            s1_tag     <= s0_tag;
        end
    end

    // S2: order by magnitude so the subtract never goes negative, then align.
    logic             al_swap;
    logic [EXP_W-1:0] al_diff;
    logic [SHW-1:0]   al_sh;
    logic [XW-1:0]    al_small_ext;
    logic [XW-1:0]    al_shifted;
    logic             al_lost;
    logic [XW-1:0]    al_small;

    always_comb begin
        al_swap      = {s1_eb, s1_mb} > {s1_ea, s1_ma};
        al_diff      = al_swap ? (s1_eb - s1_ea) : (s1_ea - s1_eb);
        al_sh        = (al_diff > CAP_E) ? CAP_S : SHW'(al_diff);
        al_small_ext = {(al_swap ? s1_ma : s1_mb), 3'b000};
        al_shifted   = al_small_ext >> al_sh;
        al_lost      = |(al_small_ext & ~({XW{1'b1}} << al_sh));
        al_small     = {al_shifted[XW-1:1], al_shifted[0] | al_lost};
    end

    logic             s2_vld;
    logic             s2_sign;
    logic             s2_eff_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [XW-1:0]    s2_big;
    logic [XW-1:0]    s2_small;
    special_t         s2_sp;
    logic             s2_sp_sign;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_eff_sub <= 1'b0;
            s2_exp     <= '0;
            s2_big     <= '0;
            s2_small   <= '0;
            s2_sp      <= SP_NONE;
            s2_sp_sign <= 1'b0;
            s2_tag     <= '0;
        end else if (advance) begin
            s2_vld     <= s1_vld;
            s2_sign    <= al_swap ? s1_sb : s1_sa;
            s2_eff_sub <= s1_sa ^ s1_sb;
            s2_exp     <= al_swap ? s1_eb : s1_ea;
            s2_big     <= {(al_swap ? s1_mb : s1_ma), 3'b000};
            s2_small   <= al_small;
            s2_sp      <= s1_sp;
            s2_sp_sign <= s1_sp_sign;
            s2_tag     <= s1_tag;
        end
    end

    // S3: magnitude add/subtract with one carry bit.
    logic [XW:0] ad_sum;

    always_comb begin
        if (s2_eff_sub) begin
            ad_sum = {1'b0, s2_big} - {1'b0, s2_small};
        end else begin
            ad_sum = {1'b0, s2_big} + {1'b0, s2_small};
        end
    end

    logic             s3_vld;
    logic             s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [XW:0]      s3_sum;
    special_t         s3_sp;
    logic             s3_sp_sign;
    logic [TAG_W-1:0] s3_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_vld     <= 1'b0;
            s3_sign    <= 1'b0;
            s3_exp     <= '0;
            s3_sum     <= '0;
            s3_sp      <= SP_NONE;
            s3_sp_sign <= 1'b0;
            s3_tag     <= '0;
        end else if (advance) begin
            s3_vld     <= s2_vld;
            s3_sign    <= s2_sign;
            s3_exp     <= s2_exp;
            s3_sum     <= ad_sum;
            s3_sp      <= s2_sp;
            s3_sp_sign <= s2_sp_sign;
            s3_tag     <= s2_tag;
        end
    end

    // S4: normalise; exponent is kept two bits wider so underflow shows as negative.
    function automatic logic [LZW-1:0] count_lz(input logic [XW-1:0] v);
        logic [LZW-1:0] cnt;
        logic           found;
        cnt   = '0;
        found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + LZW'(1);
                end
            end
        end
        return cnt;
    endfunction

    logic [LZW-1:0] nm_lz;
    logic           nm_zero;
    logic [XW-1:0]  nm_mant;
    logic [EXW-1:0] nm_exp;

    always_comb begin
        nm_lz   = count_lz(s3_sum[XW-1:0]);
        nm_zero = (s3_sum == '0);
        if (s3_sum[XW]) begin
            nm_mant = {s3_sum[XW:2], s3_sum[1] | s3_sum[0]};
            nm_exp  = EXW'(s3_exp) + EXW'(1);
        end else begin
            nm_mant = s3_sum[XW-1:0] << nm_lz;
            nm_exp  = EXW'(s3_exp) - EXW'(nm_lz);
        end
    end

    logic             s4_vld;
    logic             s4_sign;
    logic [EXW-1:0]   s4_exp;
    logic [XW-1:0]    s4_mant;
    logic             s4_zero;
    special_t         s4_sp;
    logic             s4_sp_sign;
    logic [TAG_W-1:0] s4_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s4_vld     <= 1'b0;
            s4_sign    <= 1'b0;
            s4_exp     <= '0;
            s4_mant    <= '0;
            s4_zero    <= 1'b0;
            s4_sp      <= SP_NONE;
            s4_sp_sign <= 1'b0;
            s4_tag     <= '0;
        end else if (advance) begin
            s4_vld     <= s3_vld;
            s4_sign    <= s3_sign;
            s4_exp     <= nm_exp;
            s4_mant    <= nm_mant;
            s4_zero    <= nm_zero;
            s4_sp      <= s3_sp;
            s4_sp_sign <= s3_sp_sign;
            s4_tag     <= s3_tag;
        end
    end

    // S5: round to nearest even, then pack with special cases taking priority.
    logic           rn_up;
    logic [MRW-1:0] rn_mant;
    logic           rn_carry;
    logic [MANT_W-1:0] rn_frac;
    logic [EXW-1:0] rn_exp;
    logic [W-1:0]   rn_res;
    status_t        rn_state;

    always_comb begin
        rn_up    = s4_mant[2] && (s4_mant[3] || (|s4_mant[1:0]));
        rn_mant  = {1'b0, s4_mant[XW-1:3]} + MRW'(rn_up);
        rn_carry = rn_mant[MANT_W+1];
        rn_frac  = rn_carry ? rn_mant[MANT_W:1] : rn_mant[MANT_W-1:0];
        rn_exp   = s4_exp + EXW'(rn_carry);
        rn_res   = '0;
        rn_state = ST_OK;
        if (s4_sp == SP_NAN) begin
            rn_res   = {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}};
            rn_state = ST_NAN;
        end else if (s4_sp == SP_INF) begin
            rn_res   = {s4_sp_sign, EMAX, {MANT_W{1'b0}}};
            rn_state = ST_INF;
        end else if (s4_sp == SP_ZERO) begin
            rn_res   = {s4_sp_sign, {(W-1){1'b0}}};
            rn_state = ST_NUL;
        end else if (s4_zero) begin
            rn_res   = '0;
            rn_state = ST_NUL;
        end else if (rn_exp[EXW-1] || (rn_exp == '0)) begin
            rn_res   = {s4_sign, {(W-1){1'b0}}};
            rn_state = ST_NUL;
        end else if (rn_exp >= EXW'(EMAX)) begin
            rn_res   = {s4_sign, EMAX, {MANT_W{1'b0}}};
            rn_state = ST_INF;
        end else begin
            rn_res   = {s4_sign, rn_exp[EXP_W-1:0], rn_frac};
            rn_state = ST_OK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld <= 1'b0;
            result  <= '0;
            state   <= ST_OK;
            tag_out <= '0;
        end else if (advance) begin
            res_vld <= s4_vld;
            result  <= rn_res;
            state   <= rn_state;
            tag_out <= s4_tag;
        end
    end

endmodule
